// File: rtl/fetch_pkg.sv
// Shared types for the queued fetch stage: FSM states, the request tag layout
// and default-width views of a fetch request and response.
package fetch_pkg;

    localparam int TAG_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Tag carried with every request and echoed by memory.
    typedef struct packed {
        logic [6:0] core;
        logic       epoch;
    } fetch_tag_t;

    // Request/response bus views at the default 64-bit address, 32-bit insn.
    typedef struct packed {
        logic [63:0] addr;
        fetch_tag_t  tag;
    } fetch_req_t;

    typedef struct packed {
        logic [31:0] data;
        fetch_tag_t  tag;
    } fetch_resp_t;

    function automatic logic [TAG_WIDTH-1:0] make_tag(input logic [6:0] core, input logic epoch);
        fetch_tag_t t;
        t.core  = core;
        t.epoch = epoch;
        return t;
    endfunction

endpackage

// File: rtl/fetch_insn_fifo.sv
// Instruction queue between fetch and decode. Head is shown combinationally
// from registered storage; flush empties the queue and beats push/pop.
module fetch_insn_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [WIDTH-1:0]   push_data,
    output logic [WIDTH-1:0]   head_data,
    output logic               head_valid,
    output logic [COUNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             full;

    assign head_valid = (count != '0);
    assign full       = (count == COUNT_W'(DEPTH));
    assign do_pop     = pop && head_valid;
    assign head_data  = head_valid ? slots[rd_ptr] : '0;

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + COUNT_W'(push) - COUNT_W'(do_pop);
        end
    end

    // Entry storage; contents need no reset because head is gated by head_valid.
    always_ff @(posedge clk) begin
        if (push && !flush) slots[wr_ptr] <= push_data;
    end

    // The fetch side reserves a slot before issuing, so a push into a full
    // queue without a simultaneous pop means the reservation logic is broken.
    push_into_full: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_stage_queued.sv
// Queued instruction fetch stage: one outstanding memory request at a time,
// returned instructions buffered for decode, redirects resolved by epoch tags.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_wait counters.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender keeps payload stable while valid && !ready. Responses are always accepted.
module fetch_stage_queued
    import fetch_pkg::*;
#(
    parameter int                    CORE_ID    = 0,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INSN_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [TAG_WIDTH-1:0]  mem_req_tag,
    input  logic                  mem_resp_valid,
    input  logic [TAG_WIDTH-1:0]  mem_resp_tag,
    input  logic [INSN_WIDTH-1:0] mem_resp_data,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [INSN_WIDTH-1:0] dec_insn,
    output logic [ADDR_WIDTH-1:0] dec_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0]           stat_fetched,
    output logic [31:0]           stat_wait,
`endif
    output fetch_state_t          fsm_state
);
    localparam int                    COUNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int                    ENTRY_W = INSN_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSN_WIDTH / 8);

    fetch_state_t             state;
    logic [ADDR_WIDTH-1:0]    pc;
    logic [ADDR_WIDTH-1:0]    req_pc;
    logic                     epoch;
    logic [TAG_WIDTH-1:0]     cur_tag;
    logic [COUNT_W-1:0]       count;
    logic [ENTRY_W-1:0]       head;
    logic                     req_fire;
    logic                     resp_ours;
    logic                     resp_match;
    logic                     outstanding;
    logic                     push;
    logic                     pop;

    assign cur_tag = make_tag(7'(CORE_ID), epoch);

    // Issue only with a free slot for the response; payload derives from
    // registered pc/epoch so it is stable while stalled on ready.
    assign mem_req_valid = (state == REQ) && (count < COUNT_W'(FIFO_DEPTH));
    assign mem_req_addr  = mem_req_valid ? pc : '0;
    assign mem_req_tag   = mem_req_valid ? cur_tag : '0;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Any response addressed to this core retires the outstanding request;
    // only one carrying the current epoch is kept.
    assign resp_ours  = mem_resp_valid && (mem_resp_tag[TAG_WIDTH-1:1] == 7'(CORE_ID));
    assign resp_match = mem_resp_valid && (mem_resp_tag == cur_tag);

    // After a redirect, a request is still in flight if one fires now or an
    // earlier one has not been answered this cycle.
    assign outstanding = req_fire || (((state == WAIT) || (state == DRAIN)) && !resp_ours);

    assign push = (state == WAIT) && resp_match && !redirect_valid;
    assign pop  = dec_valid && dec_ready && !redirect_valid;

    fetch_insn_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_data  ({mem_resp_data, req_pc}),
        .head_data  (head),
        .head_valid (dec_valid),
        .count      (count)
    );

    assign dec_insn  = head[ENTRY_W-1:ADDR_WIDTH];
    assign dec_pc    = head[ADDR_WIDTH-1:0];
    assign fsm_state = state;

    // Fetch sequencing: redirect overrides everything, else request/response flow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
            epoch  <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            epoch <= ~epoch;
            state <= outstanding ? DRAIN : REQ;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        pc     <= pc + PC_STEP;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_match) state <= REQ;
                end
                DRAIN: begin
                    if (resp_ours) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    // Saturating activity counters; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_wait    <= '0;
        end else begin
            if (push && (stat_fetched != '1))
                stat_fetched <= stat_fetched + 32'd1;
            if (((state == WAIT) || (state == DRAIN)) && (stat_wait != '1))
                stat_wait <= stat_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage_queued.sv
// Randomized bench for fetch_stage_queued: the bench plays memory and decode,
// and a transaction-level model predicts the instruction stream.
module tb_fetch_stage_queued;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic [7:0]  mem_req_tag;
    logic        mem_resp_valid;
    logic [7:0]  mem_resp_tag;
    logic [31:0] mem_resp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_insn;
    logic [63:0] dec_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_wait;
`endif
    fetch_pkg::fetch_state_t fsm_state;

    fetch_stage_queued #(
        .CORE_ID    (0),
        .ADDR_WIDTH (64),
        .INSN_WIDTH (32),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_tag    (mem_req_tag),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_tag   (mem_resp_tag),
        .mem_resp_data  (mem_resp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_insn       (dec_insn),
        .dec_pc         (dec_pc),
`ifdef FETCH_STATS_EN
        .stat_fetched   (stat_fetched),
        .stat_wait      (stat_wait),
`endif
        .fsm_state      (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard and model state
    logic [95:0] exp_q[$];          // {insn, pc} awaiting decode
    logic [63:0] m_pc;
    logic        m_epoch;
    logic        m_idle;
    logic        inflight;
    logic [63:0] if_addr;
    logic [7:0]  if_tag;
    logic        if_stale;
    int          if_due;
    int          cyc;
    logic [31:0] exp_fetched;
    logic [31:0] exp_wait;
    int          n_checks = 0;
    int          n_passed = 0;

    task automatic check_eq(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        else
            n_passed++;
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return addr[31:0] ^ addr[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc        = 64'h0;
        m_epoch     = 1'b0;
        m_idle      = 1'b1;
        inflight    = 1'b0;
        if_stale    = 1'b0;
        exp_fetched = '0;
        exp_wait    = '0;
    endtask

    // driver: hold reset for n cycles (entered and left on a falling edge)
    task automatic do_reset(input int n);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_tag   = '0;
        mem_resp_data  = '0;
        dec_ready      = 1'b0;
        model_reset();
        repeat (n) begin
            #1;
            check_eq("rst_req_valid", mem_req_valid, 1'b0);
            check_eq("rst_req_addr", mem_req_addr, 64'h0);
            check_eq("rst_req_tag", mem_req_tag, 8'h00);
            check_eq("rst_dec_valid", dec_valid, 1'b0);
            check_eq("rst_dec_insn", dec_insn, 32'h0);
            check_eq("rst_dec_pc", dec_pc, 64'h0);
            check_eq("rst_state", fsm_state, fetch_pkg::IDLE);
`ifdef FETCH_STATS_EN
            check_eq("rst_stat_fetched", stat_fetched, 32'h0);
            check_eq("rst_stat_wait", stat_wait, 32'h0);
`endif
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    // driver + model: one clock cycle, called on a falling edge
    task automatic step(input int p_ready, input int p_dec, input int p_redir,
                        input int lat_min, input int lat_max, input int p_foreign);
        logic        fire;
        logic        redir;
        logic        resp_real;
        logic        pop_exp;
        logic [95:0] head;

        // compare outputs against the model
        check_eq("req_valid", mem_req_valid, (!m_idle && !inflight && (exp_q.size() < DEPTH)));
        if (mem_req_valid) begin
            check_eq("req_addr", mem_req_addr, m_pc);
            check_eq("req_tag", mem_req_tag, {7'd0, m_epoch});
        end
        check_eq("dec_valid", dec_valid, (exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check_eq("dec_pc", dec_pc, head[63:0]);
            check_eq("dec_insn", dec_insn, head[95:64]);
        end
`ifdef FETCH_STATS_EN
        check_eq("stat_fetched", stat_fetched, exp_fetched);
        check_eq("stat_wait", stat_wait, exp_wait);
`endif

        // drive next-edge inputs
        mem_req_ready  = ($urandom_range(99) < p_ready);
        dec_ready      = ($urandom_range(99) < p_dec);
        redir          = ($urandom_range(999) < p_redir);
        redirect_valid = redir;
        case ($urandom_range(3))
            0:       redirect_pc = 64'h1000;
            1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
            default: redirect_pc = {32'h0, $urandom} & ~64'h3;
        endcase
        resp_real = inflight && (cyc == if_due);
        if (resp_real) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = if_tag;
            mem_resp_data  = mem_word(if_addr);
        end else if ($urandom_range(99) < p_foreign) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = {1'b1, 6'($urandom_range(63)), 1'($urandom_range(1))};
            mem_resp_data  = $urandom;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_tag   = 8'($urandom);
            mem_resp_data  = $urandom;
        end

        // what the upcoming rising edge should do
        fire = mem_req_valid && mem_req_ready;
        if (inflight && (exp_wait != '1)) exp_wait = exp_wait + 1;
        pop_exp = (exp_q.size() != 0) && dec_ready && !redir;
        if (redir) exp_q.delete();
        else if (pop_exp) void'(exp_q.pop_front());
        if (resp_real) begin
            if (!redir && !if_stale) begin
                exp_q.push_back({mem_resp_data, if_addr});
                if (exp_fetched != '1) exp_fetched = exp_fetched + 1;
            end
            inflight = 1'b0;
        end
        if (redir && inflight) if_stale = 1'b1;
        if (fire) begin
            inflight = 1'b1;
            if_addr  = m_pc;
            if_tag   = {7'd0, m_epoch};
            if_stale = redir;
            if_due   = cyc + $urandom_range(lat_max, lat_min);
            m_pc     = m_pc + 64'd4;
        end
        if (redir) begin
            m_pc    = redirect_pc;
            m_epoch = ~m_epoch;
        end
        m_idle = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        cyc   = 0;
        reset = 1'b1;
        do_reset(3);
        // steady stream, fixed two-cycle memory latency
        repeat (40) step(100, 100, 0, 2, 2, 0);
        // decode stalled: queue fills, issue stops
        repeat (40) step(100, 0, 0, 1, 3, 0);
        // decode resumes
        repeat (40) step(100, 100, 0, 1, 3, 5);
        // memory back-pressure on requests
        repeat (60) step(30, 80, 0, 1, 2, 5);
        // everything random including redirects
        repeat (1500) step(70, 60, 30, 1, 4, 5);
        // reset in mid-operation, then more random traffic
        do_reset(2);
        repeat (400) step(80, 70, 20, 1, 3, 5);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
